// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART receive-side command sequencer:
// opcodes, FSM encoding and receiver configuration defaults.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_CFG = 8'hDD;

  localparam logic       CFG_PAR_EN_RST   = 1'b1;
  localparam logic       CFG_PAR_TYP_RST  = 1'b0;
  localparam logic [5:0] CFG_PRESCALE_RST = 6'd32;

  // Config byte layout: bit7 parity enable, bit6 parity type, bits5:0 prescale.
  typedef struct packed {
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
  } cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_WAIT,
    CFG_DATA
  } state_t;

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte stream, register-file and TX handshake signals of the command sequencer.
// master = sequencer side, slave = surrounding receiver/register-file/TX logic.
interface uart_rx_cmd_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_par_err;
  logic                  rx_stp_err;

  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data;
  logic                  reg_wr_en;
  logic                  reg_rd_en;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic                  reg_rd_valid;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  rx_data, rx_valid, rx_par_err, rx_stp_err,
    input  reg_rd_data, reg_rd_valid, tx_ready,
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    output tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_par_err, rx_stp_err,
    output reg_rd_data, reg_rd_valid, tx_ready,
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Mid-frame watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle completes.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: turns byte frames into register
// writes, register reads returned over TX, and receiver configuration updates.
module uart_rx_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_rx_cmd_ctrl_if.master       bus,
  output logic                     cfg_par_en,
  output logic                     cfg_par_typ,
  output logic [5:0]               cfg_prescale,
  output logic                     busy,
  output logic                     frame_err,
  output logic [7:0]               err_cnt
);

  state_t state_q, state_d;
  cfg_t   cfg_q, rx_cfg;

  logic accepted, rx_bad;
  logic ld_addr, ld_wr_data, wr_strobe, rd_strobe, ld_tx, tx_done, ld_cfg, err_evt;
  logic tmr_en, tmr_clr, tmr_expired;

  assign accepted = bus.rx_valid & ~bus.rx_par_err & ~bus.rx_stp_err;
  assign rx_bad   = bus.rx_valid & (bus.rx_par_err | bus.rx_stp_err);
  assign rx_cfg   = cfg_t'(bus.rx_data[7:0]);
  assign tmr_clr  = accepted | (state_d != state_q);
  assign busy     = (state_q != IDLE);

  assign cfg_par_en   = cfg_q.par_en;
  assign cfg_par_typ  = cfg_q.par_typ;
  assign cfg_prescale = cfg_q.prescale;

  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ld_addr    = 1'b0;
    ld_wr_data = 1'b0;
    wr_strobe  = 1'b0;
    rd_strobe  = 1'b0;
    ld_tx      = 1'b0;
    tx_done    = 1'b0;
    ld_cfg     = 1'b0;
    err_evt    = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accepted) begin
          if      (bus.rx_data[7:0] == OP_WR)  state_d = WR_ADDR;
          else if (bus.rx_data[7:0] == OP_RD)  state_d = RD_ADDR;
          else if (bus.rx_data[7:0] == OP_CFG) state_d = CFG_DATA;
          else                                 err_evt = 1'b1;
        end else if (rx_bad) begin
          err_evt = 1'b1;
        end
      end
      WR_ADDR, WR_DATA, RD_ADDR, CFG_DATA: begin
        tmr_en = 1'b1;
        if (accepted) begin
          state_d = IDLE;
          case (state_q)
            WR_ADDR: begin ld_addr = 1'b1; state_d = WR_DATA; end
            WR_DATA: begin ld_wr_data = 1'b1; wr_strobe = 1'b1; end
            RD_ADDR: begin ld_addr = 1'b1; rd_strobe = 1'b1; state_d = RD_WAIT; end
            default: begin
              if (prescale_legal(rx_cfg.prescale)) ld_cfg  = 1'b1;
              else                                 err_evt = 1'b1;
            end
          endcase
        end else if (rx_bad || tmr_expired) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        tmr_en = 1'b1;
        // Bytes arriving while a read is outstanding are overruns: drop them.
        err_evt = bus.rx_valid;
        if (bus.reg_rd_valid) begin
          ld_tx   = 1'b1;
          state_d = TX_WAIT;
        end else if (tmr_expired) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end
      end
      TX_WAIT: begin
        err_evt = bus.rx_valid;
        if (bus.tx_ready) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_addr    <= '0;
      bus.reg_wr_data <= '0;
      bus.reg_wr_en   <= 1'b0;
      bus.reg_rd_en   <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_valid    <= 1'b0;
      frame_err       <= 1'b0;
      err_cnt         <= '0;
      cfg_q           <= '{par_en: CFG_PAR_EN_RST, par_typ: CFG_PAR_TYP_RST,
                           prescale: CFG_PRESCALE_RST};
    end else begin
      bus.reg_wr_en <= wr_strobe;
      bus.reg_rd_en <= rd_strobe;
      frame_err     <= err_evt;
      if (ld_addr)    bus.reg_addr    <= bus.rx_data[ADDR_WIDTH-1:0];
      if (ld_wr_data) bus.reg_wr_data <= bus.rx_data;
      if (ld_tx) begin
        bus.tx_data  <= bus.reg_rd_data;
        bus.tx_valid <= 1'b1;
      end else if (tx_done) begin
        bus.tx_valid <= 1'b0;
      end
      if (ld_cfg) cfg_q <= rx_cfg;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: expected strobes, TX bytes, errors
// and config changes are queued as stimulus is driven and matched by a monitor.
module tb_uart_rx_cmd_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_par_en, cfg_par_typ, busy, frame_err;
  logic [5:0] cfg_prescale;
  logic [7:0] err_cnt;

  uart_rx_cmd_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  uart_rx_cmd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_typ  (cfg_par_typ),
    .cfg_prescale (cfg_prescale),
    .busy         (busy),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_NONE, EV_WR, EV_RD, EV_TX, EV_ERR, EV_CFG} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [15:0] val;
  } ev_t;

  ev_t  sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_err     = 0;
  logic mon_en      = 1'b0;
  logic [7:0] prev_cfg;
  logic       prev_tx_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic push_err();
    if (exp_err < 255) exp_err++;
    push(EV_ERR, 16'(exp_err));
  endtask

  task automatic observe(input string tag, input ev_kind_t kind, input logic [15:0] val);
    ev_t e;
    e.kind = EV_NONE;
    e.val  = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_kind"}, 32'(kind), 32'(e.kind));
    check({tag, "_val"}, 32'(val), 32'(e.val));
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_cfg      <= {cfg_par_en, cfg_par_typ, cfg_prescale};
      prev_tx_valid <= bus.tx_valid;
    end else begin
      if (bus.reg_wr_en) observe("wr", EV_WR, {4'h0, bus.reg_addr, bus.reg_wr_data});
      if (bus.reg_rd_en) observe("rd", EV_RD, {12'h0, bus.reg_addr});
      if (bus.tx_valid && !prev_tx_valid) observe("tx", EV_TX, {8'h0, bus.tx_data});
      if (frame_err) observe("err", EV_ERR, {8'h0, err_cnt});
      if ({cfg_par_en, cfg_par_typ, cfg_prescale} != prev_cfg)
        observe("cfg", EV_CFG, {8'h0, cfg_par_en, cfg_par_typ, cfg_prescale});
      prev_cfg      <= {cfg_par_en, cfg_par_typ, cfg_prescale};
      prev_tx_valid <= bus.tx_valid;
    end
  end

  task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
    @(posedge clk); #1;
    bus.rx_data    = b;
    bus.rx_valid   = 1'b1;
    bus.rx_par_err = pe;
    bus.rx_stp_err = se;
    @(posedge clk); #1;
    bus.rx_valid   = 1'b0;
    bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    bus.rx_data      = '0;
    bus.rx_valid     = 1'b0;
    bus.rx_par_err   = 1'b0;
    bus.rx_stp_err   = 1'b0;
    bus.reg_rd_data  = '0;
    bus.reg_rd_valid = 1'b0;
    bus.tx_ready     = 1'b0;

    repeat (3) tick();
    check("rst_wr_en",   bus.reg_wr_en, 0);
    check("rst_rd_en",   bus.reg_rd_en, 0);
    check("rst_tx_vld",  bus.tx_valid, 0);
    check("rst_busy",    busy, 0);
    check("rst_ferr",    frame_err, 0);
    check("rst_addr",    bus.reg_addr, 0);
    check("rst_wdata",   bus.reg_wr_data, 0);
    check("rst_txdata",  bus.tx_data, 0);
    check("rst_errcnt",  err_cnt, 0);
    check("rst_cfg",     {cfg_par_en, cfg_par_typ, cfg_prescale}, 8'hA0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // Register write
    push(EV_WR, 16'h053C);
    send(8'hAA);
    check("wr_busy_mid", busy, 1);
    send(8'h05);
    send(8'h3C);
    check("wr_en_lat1", bus.reg_wr_en, 1);
    check("wr_busy_end", busy, 0);
    tick();
    check("wr_en_1cyc", bus.reg_wr_en, 0);

    // Register read with held-off TX handshake
    push(EV_RD, 16'h0007);
    send(8'hBB);
    send(8'h07);
    check("rd_en_lat1", bus.reg_rd_en, 1);
    tick();
    check("rd_en_1cyc", bus.reg_rd_en, 0);
    push(EV_TX, 16'h005A);
    bus.reg_rd_data  = 8'h5A;
    bus.reg_rd_valid = 1'b1;
    tick();
    bus.reg_rd_valid = 1'b0;
    check("tx_vld_up", bus.tx_valid, 1);
    check("tx_data",   bus.tx_data, 8'h5A);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) bad++;
    end
    check("tx_hold", bad, 0);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("tx_vld_down", bus.tx_valid, 0);
    check("tx_busy_end", busy, 0);

    // Configuration: legal, illegal, legal boundary
    push(EV_CFG, 16'h0050);
    send(8'hDD);
    send(8'h50);
    check("cfg_par_en",  cfg_par_en, 0);
    check("cfg_par_typ", cfg_par_typ, 1);
    check("cfg_presc",   cfg_prescale, 16);
    push_err();
    send(8'hDD);
    send(8'hC5);
    check("cfg_bad_ferr", frame_err, 1);
    check("cfg_bad_keep", {cfg_par_en, cfg_par_typ, cfg_prescale}, 8'h50);
    check("cfg_bad_cnt",  err_cnt, 1);
    push(EV_CFG, 16'h0088);
    send(8'hDD);
    send(8'h88);
    check("cfg_presc8", cfg_prescale, 8);

    // Receive errors and unknown opcodes
    push_err();
    send(8'hAA, 1'b1, 1'b0);
    check("par_err_idle", busy, 0);
    push_err();
    send(8'h11);
    check("bad_op_ferr", frame_err, 1);
    push_err();
    send(8'hAA);
    send(8'h05, 1'b0, 1'b1);
    check("stp_err_idle", busy, 0);
    push_err();
    send(8'h3C);
    check("after_abort_cnt", err_cnt, 8'(exp_err));

    // Overrun while a read is outstanding; tx_ready high ahead of valid
    push(EV_RD, 16'h0002);
    send(8'hBB);
    send(8'h02);
    push_err();
    send(8'h33);
    check("ovr_busy", busy, 1);
    check("ovr_ferr", frame_err, 1);
    bus.tx_ready     = 1'b1;
    push(EV_TX, 16'h00A5);
    bus.reg_rd_data  = 8'hA5;
    bus.reg_rd_valid = 1'b1;
    tick();
    bus.reg_rd_valid = 1'b0;
    check("ovr_tx_vld", bus.tx_valid, 1);
    tick();
    bus.tx_ready = 1'b0;
    check("ovr_tx_done", bus.tx_valid, 0);
    check("ovr_idle", busy, 0);

    // Timeout in WR_DATA
    push_err();
    send(8'hAA);
    send(8'h05);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (frame_err) begin
        k = i;
        break;
      end
    end
    check("timeout_cycles", k, TO);
    check("timeout_idle", busy, 0);

    // Saturation of the error counter
    for (int i = 0; i < 255; i++) begin
      push_err();
      send(8'h11);
    end
    check("err_sat", err_cnt, 255);

    // Reset mid-frame
    send(8'hAA);
    send(8'h05);
    push(EV_CFG, 16'h00A0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",   busy, 0);
    check("mid_rst_cnt",    err_cnt, 0);
    check("mid_rst_cfg",    {cfg_par_en, cfg_par_typ, cfg_prescale}, 8'hA0);
    check("mid_rst_addr",   bus.reg_addr, 0);
    check("mid_rst_wr_en",  bus.reg_wr_en, 0);
    exp_err = 0;
    tick();
    tick();
    rst = 1'b0;
    push_err();
    send(8'h05);
    check("post_rst_unk", frame_err, 1);
    check("post_rst_cnt", err_cnt, 1);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
